vga_framebuffer_dbuf: RTL and testbench

Parametrised successor of the single-bit VGA framebuffer. It has BPP-bit indexed pixels and a writable 24-bit palette. Two frame banks give tear-free double buffering: the swap is taken in vertical blanking. A hardware back-buffer clear FSM fills the back bank, and writes use a valid/ready handshake. Sits between the drawing engine (shader) and the VGA DAC pins; the pixel clock is clk50/2.

---
 rtl/vga_fb_pkg.sv | 28 ++
 rtl/vga_timing_gen.sv | 60 ++++++
 rtl/vga_framebuffer_dbuf.sv | 158 +++++++++++++++
 tb/tb_vga_framebuffer_dbuf.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// Shared constants, FSM encoding and palette reset contents for the
// double-buffered VGA framebuffer.
package vga_fb_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  localparam int DEF_HTOTAL   = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_VTOTAL   = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = ST_IDLE,
    CLEAR = ST_CLEAR
  } fsm_t;

  // Entry 0 is black, every other entry white, so a 1-bpp image is visible
  // without any palette programming.
  function automatic logic [23:0] pal_reset_value(input int idx);
    return (idx == 0) ? 24'h000000 : 24'hFFFFFF;
  endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-rate (clk50/2) raster counters with raw sync and blanking decode.
module vga_timing_gen
  import vga_fb_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FRONT  = DEF_H_FRONT,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BACK   = DEF_H_BACK,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FRONT  = DEF_V_FRONT,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BACK   = DEF_V_BACK,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        clk50,
  input  logic        reset_n,
  output logic        pix_phase,
  output logic        pix_en,
  output logic [10:0] hpos,
  output logic [10:0] vpos,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic        in_vblank
);
  localparam logic [10:0] HA       = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [10:0] VA       = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);

  assign pix_en = pix_phase;

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      pix_phase <= 1'b0;
      hpos      <= '0;
      vpos      <= '0;
    end else begin
      pix_phase <= ~pix_phase;
      if (pix_phase) begin
        if (hpos == H_LAST) begin
          hpos <= '0;
          vpos <= (vpos == V_LAST) ? '0 : vpos + 11'd1;
        end else begin
          hpos <= hpos + 11'd1;
        end
      end
    end
  end

  assign hs        = (hpos >= HS_START && hpos < HS_END) ? HS_POL : ~HS_POL;
  assign vs        = (vpos >= VS_START && vpos < VS_END) ? VS_POL : ~VS_POL;
  assign blank     = (hpos >= HA) || (vpos >= VA);
  assign in_vblank = (vpos >= VA);
endmodule

// File: rtl/vga_framebuffer_dbuf.sv
// Double-buffered indexed-colour framebuffer with palette, back-bank clear
// and vblank-synchronised bank swap, driving the VGA DAC.
//   state | meaning
//   IDLE  | accepting pixel writes, swap may be taken in vblank
//   CLEAR | filling the back bank, one pixel per clk50, writes stalled
module vga_framebuffer_dbuf
  import vga_fb_pkg::*;
#(
  parameter int   BPP      = 1,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FRONT  = DEF_H_FRONT,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BACK   = DEF_H_BACK,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FRONT  = DEF_V_FRONT,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BACK   = DEF_V_BACK,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic           clk50,
  input  logic           reset_n,
  input  logic           wr_valid,
  output logic           wr_ready,
  input  logic [10:0]    wr_x,
  input  logic [10:0]    wr_y,
  input  logic [BPP-1:0] wr_color,
  input  logic           swap_req,
  output logic           swap_pending,
  output logic           swap_done,
  input  logic           clear_req,
  input  logic [BPP-1:0] clear_color,
  output logic           busy,
  input  logic           pal_we,
  input  logic [BPP-1:0] pal_addr,
  input  logic [23:0]    pal_data,
  output logic           front_bank,
  output logic [7:0]     VGA_R,
  output logic [7:0]     VGA_G,
  output logic [7:0]     VGA_B,
  output logic           VGA_CLK,
  output logic           VGA_HS,
  output logic           VGA_VS,
  output logic           VGA_BLANK_n,
  output logic           VGA_SYNC_n
);
  localparam int NPIX = H_ACTIVE * V_ACTIVE;
  localparam int AW   = $clog2(NPIX);
  localparam int NPAL = 1 << BPP;
  localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);

  logic           pix_phase, pix_en, hs_raw, vs_raw, blank_raw, in_vblank;
  logic [10:0]    hpos, vpos;
  fsm_t           state;
  logic [AW-1:0]  clr_cnt, wr_lin, rd_lin;
  logic [BPP-1:0] clr_fill, rd_idx;
  logic           take_swap, wr_fire;
  logic           mem_we;
  logic [AW:0]    mem_waddr;
  logic [BPP-1:0] mem_wdata;
  logic           hs_d1, vs_d1, blank_d1;
  logic [BPP-1:0] mem [0:(2**(AW+1))-1];
  logic [23:0]    pal [NPAL];

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_timing (
    .clk50(clk50), .reset_n(reset_n), .pix_phase(pix_phase), .pix_en(pix_en),
    .hpos(hpos), .vpos(vpos), .hs(hs_raw), .vs(vs_raw), .blank(blank_raw),
    .in_vblank(in_vblank)
  );

  assign VGA_CLK    = pix_phase;
  assign VGA_SYNC_n = 1'b1;
  assign wr_ready   = (state == IDLE);
  assign busy       = (state == CLEAR);
  assign take_swap  = swap_pending & (state == IDLE) & in_vblank;
  // Out-of-range writes complete the handshake but never reach memory.
  assign wr_fire    = wr_valid & wr_ready & (wr_x < 11'(H_ACTIVE)) & (wr_y < 11'(V_ACTIVE));
  assign wr_lin     = AW'(32'(wr_y) * 32'(H_ACTIVE) + 32'(wr_x));
  assign rd_lin     = AW'(32'(vpos) * 32'(H_ACTIVE) + 32'(hpos));

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = {~front_bank, wr_lin};
    mem_wdata = wr_color;
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = {~front_bank, clr_cnt};
      mem_wdata = clr_fill;
    end else if (wr_fire) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk50) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (pix_en) rd_idx <= mem[{front_bank, rd_lin}];
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      clr_cnt      <= '0;
      clr_fill     <= '0;
      front_bank   <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      swap_done    <= take_swap;
      swap_pending <= swap_req | (swap_pending & ~take_swap);
      if (take_swap) front_bank <= ~front_bank;
      case (state)
        IDLE: if (clear_req) begin
          state    <= CLEAR;
          clr_cnt  <= '0;
          clr_fill <= clear_color;
        end
        CLEAR: begin
          if (clr_cnt == LAST_PIX) state <= IDLE;
          else clr_cnt <= clr_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NPAL; i++) pal[i] <= pal_reset_value(i);
    end else if (pal_we) begin
      pal[pal_addr] <= pal_data;
    end
  end

  // Sync and blank ride the same two pixel slots as memory read and palette.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      hs_d1                 <= ~HS_POL;
      vs_d1                 <= ~VS_POL;
      blank_d1              <= 1'b1;
      VGA_HS                <= ~HS_POL;
      VGA_VS                <= ~VS_POL;
      VGA_BLANK_n           <= 1'b0;
      {VGA_R, VGA_G, VGA_B} <= 24'h000000;
    end else if (pix_en) begin
      hs_d1                 <= hs_raw;
      vs_d1                 <= vs_raw;
      blank_d1              <= blank_raw;
      VGA_HS                <= hs_d1;
      VGA_VS                <= vs_d1;
      VGA_BLANK_n           <= ~blank_d1;
      {VGA_R, VGA_G, VGA_B} <= blank_d1 ? 24'h000000 : pal[rd_idx];
    end
  end
endmodule

// File: tb/tb_vga_framebuffer_dbuf.sv
// Self-checking bench: small raster, cycle-stepped reference model built from
// raster arithmetic on the cycle count plus bank/palette arrays.
module tb_vga_framebuffer_dbuf;
  localparam int BPP = 4;
  localparam int HA = 16, HF = 2, HSW = 4, HB = 2;
  localparam int VA = 8, VF = 1, VSW = 2, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int NPIX = HA * VA;
  localparam int NPAL = 1 << BPP;
  localparam int FRAME = 2 * HT * VT;
  localparam bit HPOL = 1'b0, VPOL = 1'b0;

  logic clk50 = 1'b0, reset_n = 1'b0;
  logic wr_valid = 1'b0, wr_ready;
  logic [10:0] wr_x = '0, wr_y = '0;
  logic [BPP-1:0] wr_color = '0, clear_color = '0, pal_addr = '0;
  logic swap_req = 1'b0, swap_pending, swap_done, clear_req = 1'b0, busy;
  logic pal_we = 1'b0;
  logic [23:0] pal_data = '0;
  logic front_bank;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n;

  always #5 clk50 = ~clk50;

  vga_framebuffer_dbuf #(
    .BPP(BPP), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk50(clk50), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .swap_req(swap_req),
    .swap_pending(swap_pending), .swap_done(swap_done), .clear_req(clear_req),
    .clear_color(clear_color), .busy(busy), .pal_we(pal_we), .pal_addr(pal_addr),
    .pal_data(pal_data), .front_bank(front_bank), .VGA_R(VGA_R), .VGA_G(VGA_G),
    .VGA_B(VGA_B), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_n(VGA_BLANK_n), .VGA_SYNC_n(VGA_SYNC_n)
  );

  int errors = 0, checks = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model. fb value -1 means never written (unknown colour).
  int fb [2][NPIX];
  logic [23:0] pal_m [NPAL];
  int k;
  bit m_front, m_pend, m_clr, m_done;
  int m_cnt, m_fill;
  bit s1_hs, s1_vs, s1_blank;
  int s1_idx;
  bit e_hs, e_vs, e_bn, e_known;
  logic [23:0] e_rgb;

  task automatic model_reset();
    k = 0; m_front = 0; m_pend = 0; m_clr = 0; m_done = 0; m_cnt = 0; m_fill = 0;
    for (int i = 0; i < NPAL; i++) pal_m[i] = (i == 0) ? 24'h000000 : 24'hFFFFFF;
    s1_hs = !HPOL; s1_vs = !VPOL; s1_blank = 1; s1_idx = 0;
    e_hs = !HPOL; e_vs = !VPOL; e_bn = 0; e_rgb = 24'h0; e_known = 1;
  endtask

  task automatic check_all(input string tag);
    logic [23:0] grgb;
    logic [63:0] got, exp;
    grgb = e_known ? {VGA_R, VGA_G, VGA_B} : 24'h0;
    got = {30'd0, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n, grgb,
           busy, wr_ready, swap_pending, swap_done, front_bank};
    exp = {30'd0, 1'(k % 2), e_hs, e_vs, e_bn, 1'b1, (e_known ? e_rgb : 24'h0),
           m_clr, !m_clr, m_pend, m_done, m_front};
    chk_eq(tag, got, exp);
  endtask

  function automatic bit in_vb_now();
    return ((k / 2) / HT) % VT >= VA;
  endfunction

  task automatic step(input string tag);
    int p, h, v;
    bit take;
    p = k / 2; h = p % HT; v = (p / HT) % VT;
    if (k % 2 == 1) begin
      e_hs = s1_hs; e_vs = s1_vs; e_bn = !s1_blank;
      if (s1_blank) begin e_rgb = 24'h0; e_known = 1; end
      else if (s1_idx < 0) e_known = 0;
      else begin e_rgb = pal_m[s1_idx]; e_known = 1; end
      s1_hs = (h >= HA + HF && h < HA + HF + HSW) ? HPOL : !HPOL;
      s1_vs = (v >= VA + VF && v < VA + VF + VSW) ? VPOL : !VPOL;
      s1_blank = (h >= HA) || (v >= VA);
      s1_idx = s1_blank ? 0 : fb[m_front][v * HA + h];
    end
    take = m_pend && !m_clr && (v >= VA);
    if (wr_valid && !m_clr && int'(wr_x) < HA && int'(wr_y) < VA)
      fb[!m_front][int'(wr_y) * HA + int'(wr_x)] = int'(wr_color);
    if (m_clr) begin
      fb[!m_front][m_cnt] = m_fill;
      if (m_cnt == NPIX - 1) m_clr = 0; else m_cnt++;
    end else if (clear_req) begin
      m_clr = 1; m_cnt = 0; m_fill = int'(clear_color);
    end
    if (pal_we) pal_m[pal_addr] = pal_data;
    m_pend = swap_req || (m_pend && !take);
    if (take) m_front = !m_front;
    m_done = take;
    @(posedge clk50); #1;
    k++;
    wr_valid = 0; swap_req = 0; clear_req = 0; pal_we = 0;
    check_all(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic do_reset();
    reset_n = 0;
    wr_valid = 0; swap_req = 0; clear_req = 0; pal_we = 0;
    #1;
    model_reset();
    check_all("reset_async");
    repeat (3) @(posedge clk50);
    #1;
    check_all("reset_hold");
    reset_n = 1;
  endtask

  task automatic write_px(input int x, input int y, input int c, input string tag);
    wr_valid = 1; wr_x = 11'(x); wr_y = 11'(y); wr_color = BPP'(c);
    step(tag);
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NPIX; i++) fb[b][i] = -1;
    model_reset();
    @(posedge clk50); #1;
    do_reset();
    run(2 * FRAME, "idle_timing");

    // Clear both banks to index 0, swapping between them.
    clear_req = 1; clear_color = '0; step("clear_start");
    run(NPIX + 4, "clear_back");
    swap_req = 1; step("swap_req");
    run(FRAME, "swap_to_1");
    clear_req = 1; clear_color = '0; step("clear_start2");
    run(NPIX + 4, "clear_back2");

    // Palette entry and back-bank writes, invisible until swap.
    pal_we = 1; pal_addr = BPP'(3); pal_data = 24'h12AB34; step("pal_write");
    write_px(10, 5, 1, "wr_10_5");
    write_px(3, 2, 3, "wr_3_2");
    write_px(HA, 0, 3, "wr_oob_x");
    write_px(0, VA, 3, "wr_oob_y");
    run(FRAME, "no_swap_yet");
    for (int i = 0; i < 2 * FRAME && ((k / 2) / HT) % VT != 2; i++) step("seek_row2");
    swap_req = 1; step("swap_mid_frame");
    run(2 * FRAME, "after_swap");

    // Clear crossing into vblank with a swap requested meanwhile.
    for (int i = 0; i < 2 * FRAME && !(((k / 2) / HT) % VT == VA - 1 && (k / 2) % HT == 0); i++)
      step("seek_last_row");
    clear_req = 1; clear_color = BPP'(5); step("clear_span");
    run(10, "clear_span");
    swap_req = 1; step("swap_during_clear");
    run(2 * FRAME, "deferred_swap");

    // swap_req on the very cycle a swap is taken re-arms it.
    swap_req = 1; step("arm_swap");
    for (int i = 0; i < 2 * FRAME && !(m_pend && !m_clr && in_vb_now()); i++) step("seek_take");
    swap_req = 1; step("swap_on_take");
    run(2 * FRAME, "second_swap");

    // Reset mid-clear with a swap pending.
    clear_req = 1; clear_color = BPP'(7); step("clear_then_reset");
    swap_req = 1; step("clear_then_reset");
    run(20, "clear_then_reset");
    do_reset();
    run(FRAME, "post_reset");

    // Randomised traffic.
    for (int i = 0; i < 15000; i++) begin
      wr_valid    = 1'($urandom_range(0, 1));
      wr_x        = 11'($urandom_range(0, HA + 3));
      wr_y        = 11'($urandom_range(0, VA + 2));
      wr_color    = BPP'($urandom);
      swap_req    = ($urandom_range(0, 299) == 0);
      clear_req   = ($urandom_range(0, 999) == 0);
      clear_color = BPP'($urandom);
      pal_we      = ($urandom_range(0, 499) == 0);
      pal_addr    = BPP'($urandom);
      pal_data    = 24'($urandom);
      step("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
